// File: rtl/simple2_out_capture_if.sv
// rtl/simple2_out_capture_if.sv - bit-stream in / word-stream out bundle for simple2_out_capture
//
// Purpose: groups the serial result-bit handshake and the packed-word handshake
//   of the simple2 capture stage.
// Signals:
//   bit_in, bit_valid, bit_ready        serial result bit and its handshake
//   word_out, ones_cnt                  packed word (LSB = first bit) and its popcount
//   word_valid, word_ready              packed-word handshake
//   overrun                             sticky: bit offered while the stage was full
// Modports:
//   master  environment side (drives bits, consumes words)
//   slave   capture stage side
interface simple2_out_capture_if #(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH + 1)
);
  logic             bit_in;
  logic             bit_valid;
  logic             bit_ready;
  logic [WIDTH-1:0] word_out;
  logic [CNT_W-1:0] ones_cnt;
  logic             word_valid;
  logic             word_ready;
  logic             overrun;

  modport master (
    output bit_in, bit_valid, word_ready,
    input  bit_ready, word_out, ones_cnt, word_valid, overrun
  );

  modport slave (
    input  bit_in, bit_valid, word_ready,
    output bit_ready, word_out, ones_cnt, word_valid, overrun
  );
endinterface

// File: rtl/simple2_out_capture.sv
// rtl/simple2_out_capture.sv - packs the simple2 'out' bit stream LSB-first into words with popcount
//
// Purpose: serially accepts result bits, assembles WIDTH-bit words LSB-first,
//   and presents each completed word plus its popcount over valid/ready. The
//   next word accumulates while the previous one waits for the consumer.
// Ports:
//   iccad_clk   in   clock, rising edge
//   iccad_rst   in   synchronous reset, active-high
//   bus         slave modport of simple2_out_capture_if (bit and word handshakes, overrun)
module simple2_out_capture #(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic                   iccad_clk,
  input  logic                   iccad_rst,
  simple2_out_capture_if.slave   bus
);

  // FILL: no word presented; FILL_HOLD: a finished word awaits the consumer.
  // In both states the next word keeps accumulating.
  typedef enum logic {
    FILL      = 1'b0,
    FILL_HOLD = 1'b1
  } state_t;

  state_t           r_state;
  state_t           w_state_next;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_next;
  logic [WIDTH-1:0] r_sr;
  logic [WIDTH-1:0] w_sr_next;
  logic [WIDTH-1:0] r_word;
  logic [CNT_W-1:0] r_ones;
  logic             r_overrun;

  logic [WIDTH-1:0] w_word_new;
  logic [CNT_W-1:0] w_ones_new;
  logic             w_last;
  logic             w_hold;
  logic             w_stall;
  logic             w_bit_ready;
  logic             w_bit_acc;
  logic             w_word_acc;
  logic             w_complete;

  assign w_hold      = (r_state == FILL_HOLD);
  assign w_last      = (r_cnt == CNT_W'(WIDTH - 1));
  // Only the word-completing bit has to wait: it needs the output register free.
  assign w_stall     = w_last && w_hold && !bus.word_ready;
  assign w_bit_ready = !iccad_rst && !w_stall;
  assign w_bit_acc   = bus.bit_valid && w_bit_ready;
  assign w_word_acc  = w_hold && bus.word_ready;
  assign w_complete  = w_bit_acc && w_last;

  // The completing bit goes straight into the word's MSB instead of the shift register.
  assign w_word_new  = {bus.bit_in, r_sr[WIDTH-2:0]};

  always_comb begin
    w_ones_new = '0;
    for (int i = 0; i < WIDTH; i++) begin
      w_ones_new = w_ones_new + CNT_W'(w_word_new[i]);
    end
  end

  // Decoded write of the accepted bit into its slot.
  always_comb begin
    w_sr_next = r_sr;
    for (int i = 0; i < WIDTH; i++) begin
      if (r_cnt == CNT_W'(i)) begin
        w_sr_next[i] = bus.bit_in;
      end
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    if (w_complete) begin
      // A completion reloads the output register even if the consumer takes
      // the old word on this same edge, so word_valid stays high.
      w_state_next = FILL_HOLD;
      w_cnt_next   = '0;
    end else begin
      if (w_bit_acc) begin
        w_cnt_next = r_cnt + CNT_W'(1);
      end
      if (w_word_acc) begin
        w_state_next = FILL;
      end
    end
  end

  always_ff @(posedge iccad_clk) begin
    if (iccad_rst) begin
      r_state <= FILL;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_ff @(posedge iccad_clk) begin
    if (iccad_rst) begin
      r_cnt     <= '0;
      r_sr      <= '0;
      r_word    <= '0;
      r_ones    <= '0;
      r_overrun <= 1'b0;
    end else begin
      r_cnt <= w_cnt_next;
      if (w_complete) begin
        r_sr   <= '0;
        r_word <= w_word_new;
        r_ones <= w_ones_new;
      end else if (w_bit_acc) begin
        r_sr <= w_sr_next;
      end
      if (bus.bit_valid && !w_bit_ready) begin
        r_overrun <= 1'b1;
      end
    end
  end

  assign bus.bit_ready  = w_bit_ready;
  assign bus.word_out   = r_word;
  assign bus.ones_cnt   = r_ones;
  assign bus.word_valid = w_hold;
  assign bus.overrun    = r_overrun;

endmodule
